icache_set_filler: RTL and testbench

Write-side controller for one instruction-cache set RAM (256 × 128-bit, single port, 1-cycle registered read). Assembles two 64-bit refill beats from memory into one 128-bit set line and writes it at a latched index. Also sweeps all 256 entries to zero on flush. Forwards lookup reads to the RAM port whenever idle; sits between the icache controller/memory interface and one `set_ram` instance.

---
 rtl/icache_set_filler_pkg.sv | 17 +
 rtl/icache_set_filler_if.sv | 38 +++
 rtl/icache_set_filler.sv | 114 +++++++++++
 tb/tb_icache_set_filler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_set_filler_pkg.sv
// Shared icache set-filler parameters and FSM state encoding.
package icache_set_filler_pkg;

  localparam int unsigned WORD_SIZE  = 64;
  localparam int unsigned SET_WIDTH  = 2 * WORD_SIZE;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    WRITE = 3'd3,
    FLUSH = 3'd4
  } filler_state_t;

endpackage

// File: rtl/icache_set_filler_if.sv
// Refill, flush, lookup and set-RAM signals of one icache set filler.
interface icache_set_filler_if;
  import icache_set_filler_pkg::*;

  logic                  fill_req_i;
  logic [ADDR_WIDTH-1:0] fill_addr_i;
  logic                  fill_ready_o;
  logic                  mem_valid_i;
  logic [WORD_SIZE-1:0]  mem_data_i;
  logic                  mem_ready_o;
  logic                  flush_i;
  logic                  lookup_req_i;
  logic [ADDR_WIDTH-1:0] lookup_addr_i;
  logic                  lookup_gnt_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  ram_req_o;
  logic                  ram_we_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [SET_WIDTH-1:0]  ram_data_o;

  // Filler side.
  modport slave (
    input  fill_req_i, fill_addr_i, mem_valid_i, mem_data_i, flush_i,
           lookup_req_i, lookup_addr_i,
    output fill_ready_o, mem_ready_o, lookup_gnt_o, busy_o, done_o,
           ram_req_o, ram_we_o, ram_addr_o, ram_data_o
  );

  // Controller / memory / RAM side.
  modport master (
    output fill_req_i, fill_addr_i, mem_valid_i, mem_data_i, flush_i,
           lookup_req_i, lookup_addr_i,
    input  fill_ready_o, mem_ready_o, lookup_gnt_o, busy_o, done_o,
           ram_req_o, ram_we_o, ram_addr_o, ram_data_o
  );

endinterface

// File: rtl/icache_set_filler.sv
// Write-side controller for one icache set RAM: two-beat refill, zero sweep on
// flush, and lookup passthrough while idle.
module icache_set_filler
  import icache_set_filler_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  icache_set_filler_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  filler_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [SET_WIDTH-1:0]  line_q;
  logic                  pend_q;
  logic                  done_q;
  logic                  start_flush;
  logic                  start_fill;

  // Next state and RAM-side outputs; everything is held low during reset.
  always_comb begin
    state_d          = state_q;
    start_flush      = 1'b0;
    start_fill       = 1'b0;
    bus.fill_ready_o = 1'b0;
    bus.mem_ready_o  = 1'b0;
    bus.lookup_gnt_o = 1'b0;
    bus.busy_o       = 1'b0;
    bus.ram_req_o    = 1'b0;
    bus.ram_we_o     = 1'b0;
    bus.ram_addr_o   = '0;
    bus.ram_data_o   = '0;
    if (!rst_i) begin
      bus.busy_o = (state_q != IDLE) || pend_q;
      case (state_q)
        IDLE: begin
          if (bus.flush_i || pend_q) begin
            start_flush = 1'b1;
            state_d     = FLUSH;
          end else begin
            bus.fill_ready_o = 1'b1;
            if (bus.fill_req_i) begin
              start_fill = 1'b1;
              state_d    = BEAT0;
            end else begin
              bus.lookup_gnt_o = bus.lookup_req_i;
              bus.ram_req_o    = bus.lookup_req_i;
              bus.ram_addr_o   = bus.lookup_addr_i;
            end
          end
        end
        BEAT0: begin
          bus.mem_ready_o = 1'b1;
          if (bus.mem_valid_i) state_d = BEAT1;
        end
        BEAT1: begin
          bus.mem_ready_o = 1'b1;
          if (bus.mem_valid_i) state_d = WRITE;
        end
        WRITE: begin
          bus.ram_req_o  = 1'b1;
          bus.ram_we_o   = 1'b1;
          bus.ram_addr_o = idx_q;
          bus.ram_data_o = line_q;
          state_d        = IDLE;
        end
        FLUSH: begin
          bus.ram_req_o  = 1'b1;
          bus.ram_we_o   = 1'b1;
          bus.ram_addr_o = cnt_q;
          if (cnt_q == LAST_IDX) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: line assembly, latched index, sweep counter, pending flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      line_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == WRITE) || ((state_q == FLUSH) && (cnt_q == LAST_IDX));
      if (start_flush) begin
        cnt_q  <= '0;
        pend_q <= 1'b0;
      end
      if (start_fill) idx_q <= bus.fill_addr_i;
      if (state_q == FLUSH) cnt_q <= cnt_q + ADDR_WIDTH'(1);
      // A flush arriving mid-fill waits for the fill write to land first.
      if (bus.flush_i && ((state_q == BEAT0) || (state_q == BEAT1) || (state_q == WRITE)))
        pend_q <= 1'b1;
      if ((state_q == BEAT0) && bus.mem_valid_i) line_q[WORD_SIZE-1:0] <= bus.mem_data_i;
      if ((state_q == BEAT1) && bus.mem_valid_i) line_q[SET_WIDTH-1:WORD_SIZE] <= bus.mem_data_i;
    end
  end

  assign bus.done_o = done_q;

endmodule

// File: tb/tb_icache_set_filler.sv
// Self-checking bench for icache_set_filler with a behavioural set RAM and
// a reference model of the expected RAM contents.
module tb_icache_set_filler;
  import icache_set_filler_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  icache_set_filler_if bus ();
  icache_set_filler dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Stand-in set RAM plus a log of every write it receives.
  logic [SET_WIDTH-1:0]  ram [DEPTH];
  logic [SET_WIDTH-1:0]  rdata;
  logic [ADDR_WIDTH-1:0] wlog_addr [$];
  logic [SET_WIDTH-1:0]  wlog_data [$];
  always @(posedge clk_i) begin
    if (bus.ram_req_o && bus.ram_we_o) begin
      ram[bus.ram_addr_o] <= bus.ram_data_o;
      wlog_addr.push_back(bus.ram_addr_o);
      wlog_data.push_back(bus.ram_data_o);
    end else if (bus.ram_req_o) begin
      rdata <= ram[bus.ram_addr_o];
    end
  end

  logic [SET_WIDTH-1:0] ref_mem [DEPTH];

  typedef struct packed {
    logic                  flush;
    logic                  fill;
    logic                  lk;
    logic [ADDR_WIDTH-1:0] la;
    logic                  e_ready;
    logic                  e_gnt;
    logic                  e_req;
    logic [ADDR_WIDTH-1:0] e_addr;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [SET_WIDTH-1:0] act,
                     input logic [SET_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_log();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  // Waits for done_o; cycles is the cycle offset from the start cycle T.
  task automatic wait_done(input int start, output int cycles, output int gnts);
    cycles = start;
    gnts   = 0;
    while (!bus.done_o && cycles < 400) begin
      gnts += int'(bus.lookup_gnt_o);
      step();
      cycles++;
    end
    chk("done_timeout", SET_WIDTH'(bus.done_o), SET_WIDTH'(1));
  endtask

  task automatic idle_inputs();
    bus.fill_req_i = 0; bus.fill_addr_i = '0; bus.mem_valid_i = 0; bus.mem_data_i = '0;
    bus.flush_i = 0; bus.lookup_req_i = 0; bus.lookup_addr_i = '0;
  endtask

  task automatic do_fill(input logic [7:0] a, input logic [63:0] b0, input logic [63:0] b1,
                         input int s0, input int s1);
    bus.fill_req_i = 1; bus.fill_addr_i = a;
    #1 chk("fill_ready", SET_WIDTH'(bus.fill_ready_o), SET_WIDTH'(1));
    step();
    bus.fill_req_i = 0;
    for (int i = 0; i < s0 + s1 + 2; i++) begin
      bus.mem_valid_i  = (i == s0) || (i == s0 + s1 + 1);
      bus.mem_data_i   = (i == s0) ? b0 : b1;
      bus.lookup_req_i = !bus.mem_valid_i;
      bus.lookup_addr_i = ADDR_WIDTH'($urandom);
      #1;
      chk("beat_ready", SET_WIDTH'(bus.mem_ready_o), SET_WIDTH'(1));
      if (!bus.mem_valid_i) begin
        chk("stall_gnt", SET_WIDTH'(bus.lookup_gnt_o), '0);
        chk("stall_noreq", SET_WIDTH'(bus.ram_req_o), '0);
      end
      step();
    end
    bus.mem_valid_i = 0; bus.lookup_req_i = 0;
    #1;
    chk("fill_we", SET_WIDTH'(bus.ram_we_o), SET_WIDTH'(1));
    chk("fill_addr", SET_WIDTH'(bus.ram_addr_o), SET_WIDTH'(a));
    chk("fill_data", bus.ram_data_o, {b1, b0});
    step();
    chk("fill_done", SET_WIDTH'(bus.done_o), SET_WIDTH'(1));
    ref_mem[a] = {b1, b0};
  endtask

  task automatic do_lookup(input logic [7:0] a);
    bus.lookup_req_i = 1; bus.lookup_addr_i = a;
    #1;
    chk("lk_gnt", SET_WIDTH'(bus.lookup_gnt_o), SET_WIDTH'(1));
    chk("lk_rd", SET_WIDTH'({bus.ram_req_o, bus.ram_we_o}), SET_WIDTH'(2'b10));
    step();
    bus.lookup_req_i = 0;
    chk("lk_data", rdata, ref_mem[a]);
  endtask

  // Full sweep from IDLE, optionally with a competing fill request at T.
  task automatic do_flush(input logic with_fill);
    int cyc, g, bad;
    clear_log();
    bus.flush_i = 1; bus.fill_req_i = with_fill; bus.fill_addr_i = 8'h99;
    bus.lookup_req_i = 1; bus.lookup_addr_i = 8'h44;
    #1;
    chk("flush_ready", SET_WIDTH'(bus.fill_ready_o), '0);
    chk("flush_gnt0", SET_WIDTH'(bus.lookup_gnt_o), '0);
    step();
    bus.flush_i = 0; bus.fill_req_i = 0;
    wait_done(1, cyc, g);
    bus.lookup_req_i = 0;
    chk("flush_latency", SET_WIDTH'(cyc), SET_WIDTH'(257));
    chk("flush_gnt", SET_WIDTH'(g), '0);
    chk("flush_nwrites", SET_WIDTH'(wlog_addr.size()), SET_WIDTH'(256));
    bad = 0;
    for (int i = 0; i < wlog_addr.size(); i++)
      if (wlog_addr[i] != ADDR_WIDTH'(i) || wlog_data[i] != '0) bad++;
    chk("flush_seq", SET_WIDTH'(bad), '0);
    step();
    chk("flush_idle", SET_WIDTH'({bus.busy_o, bus.done_o}), '0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, g, nw;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 8'h10};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};

    // Reset with every request asserted: all outputs low.
    idle_inputs();
    rst_i = 1; bus.fill_req_i = 1; bus.flush_i = 1; bus.lookup_req_i = 1; bus.mem_valid_i = 1;
    step(); step();
    chk("rst_outs", SET_WIDTH'({bus.ram_req_o, bus.ram_we_o, bus.mem_ready_o, bus.lookup_gnt_o,
                                bus.busy_o, bus.fill_ready_o, bus.done_o}), '0);
    idle_inputs();
    step();
    rst_i = 0;
    step();

    // Idle arbitration table: applied and withdrawn between clock edges.
    foreach (vecs[i]) begin
      bus.flush_i = vecs[i].flush; bus.fill_req_i = vecs[i].fill;
      bus.lookup_req_i = vecs[i].lk; bus.lookup_addr_i = vecs[i].la;
      #1;
      chk($sformatf("vec%0d_ready", i), SET_WIDTH'(bus.fill_ready_o), SET_WIDTH'(vecs[i].e_ready));
      chk($sformatf("vec%0d_gnt", i), SET_WIDTH'(bus.lookup_gnt_o), SET_WIDTH'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_req", i), SET_WIDTH'({bus.ram_req_o, bus.ram_we_o}),
          SET_WIDTH'({vecs[i].e_req, 1'b0}));
      chk($sformatf("vec%0d_addr", i), SET_WIDTH'(bus.ram_addr_o), SET_WIDTH'(vecs[i].e_addr));
      chk($sformatf("vec%0d_busy", i), SET_WIDTH'(bus.busy_o), '0);
      idle_inputs();
      step();
    end

    // Basic fill, then lookup of the written line.
    clear_log();
    do_fill(8'h3C, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, 0);
    step();
    chk("basic_done_pulse", SET_WIDTH'(bus.done_o), '0);
    chk("basic_nwrites", SET_WIDTH'(wlog_addr.size()), SET_WIDTH'(1));
    do_lookup(8'h3C);
    chk("basic_value", rdata, {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444});

    // Five stall cycles between beats.
    do_fill(8'h55, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 0, 5);
    do_lookup(8'h55);

    // Flush after pre-writing the edge indices.
    do_fill(8'hFF, 64'hA5A5, 64'h5A5A, 2, 1);
    do_fill(8'h00, 64'h1234, 64'h5678, 0, 0);
    do_flush(1'b0);
    do_lookup(8'hFF);
    do_lookup(8'h00);

    // Flush raised during BEAT1: fill write first, then one sweep.
    clear_log();
    bus.fill_req_i = 1; bus.fill_addr_i = 8'h77;
    step();
    bus.fill_req_i = 0; bus.mem_valid_i = 1; bus.mem_data_i = 64'h0A0A;
    step();
    bus.mem_data_i = 64'h0B0B; bus.flush_i = 1;
    #1 chk("ovl_beat1", SET_WIDTH'(bus.mem_ready_o), SET_WIDTH'(1));
    step();
    bus.flush_i = 0; bus.mem_valid_i = 0;
    #1;
    chk("ovl_write", SET_WIDTH'({bus.ram_we_o, bus.ram_addr_o}), SET_WIDTH'({1'b1, 8'h77}));
    chk("ovl_data", bus.ram_data_o, {64'h0B0B, 64'h0A0A});
    step();
    bus.fill_req_i = 1; bus.fill_addr_i = 8'h12;
    #1;
    chk("ovl_pend", SET_WIDTH'({bus.done_o, bus.busy_o, bus.fill_ready_o, bus.ram_req_o}),
        SET_WIDTH'(4'b1100));
    step();
    bus.fill_req_i = 0; bus.flush_i = 1;
    #1 chk("ovl_flush_start", SET_WIDTH'({bus.ram_we_o, bus.ram_addr_o}), SET_WIDTH'({1'b1, 8'h00}));
    step();
    bus.flush_i = 0;
    wait_done(2, cyc, g);
    chk("ovl_latency", SET_WIDTH'(cyc), SET_WIDTH'(257));
    step();
    chk("ovl_one_sweep", SET_WIDTH'(bus.busy_o), '0);
    chk("ovl_nwrites", SET_WIDTH'(wlog_addr.size()), SET_WIDTH'(257));
    chk("ovl_first", SET_WIDTH'(wlog_addr[0]), SET_WIDTH'(8'h77));
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Flush and fill in the same idle cycle.
    do_flush(1'b1);

    // Reset after beat 0: no write, idle and ready right after.
    clear_log();
    bus.fill_req_i = 1; bus.fill_addr_i = 8'h21;
    step();
    bus.fill_req_i = 0; bus.mem_valid_i = 1; bus.mem_data_i = 64'hEEEE;
    step();
    rst_i = 1; bus.mem_data_i = 64'hFFFF;
    #1 chk("rstfill_ready", SET_WIDTH'({bus.mem_ready_o, bus.busy_o}), '0);
    step();
    rst_i = 0; bus.mem_valid_i = 0;
    #1 chk("rstfill_idle", SET_WIDTH'({bus.busy_o, bus.fill_ready_o}), SET_WIDTH'(2'b01));
    repeat (4) step();
    chk("rstfill_nowrite", SET_WIDTH'(wlog_addr.size()), '0);

    // Reset at flush index 100: sweep stops and does not resume.
    bus.flush_i = 1;
    step();
    bus.flush_i = 0;
    repeat (100) step();
    chk("rstflush_idx", SET_WIDTH'(bus.ram_addr_o), SET_WIDTH'(100));
    rst_i = 1;
    #1 chk("rstflush_req", SET_WIDTH'(bus.ram_req_o), '0);
    step();
    rst_i = 0;
    nw = wlog_addr.size();
    repeat (5) step();
    chk("rstflush_stop", SET_WIDTH'({bus.busy_o, 16'(wlog_addr.size())}), SET_WIDTH'(nw));
    chk("rstflush_count", SET_WIDTH'(nw), SET_WIDTH'(100));

    // Random fills, lookups and flushes against the contents model.
    do_flush(1'b0);
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op < 13)
        do_fill(ADDR_WIDTH'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op < 19)
        do_lookup(ADDR_WIDTH'($urandom));
      else
        do_flush(1'($urandom));
      step();
    end
    for (int i = 0; i < 24; i++) do_lookup(ADDR_WIDTH'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
